// File: rtl/uart_cmd_defs_pkg.sv
// rtl/uart_cmd_defs_pkg.sv - shared constants and encodings for the UART command controller
package uart_cmd_defs;

    localparam logic [7:0] SOF = 8'hA5;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_TOG   = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CHK     = 2'b01,
        ERR_ADDR    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_ADDR = 2'b01,
        WAIT_DATA = 2'b10,
        WAIT_CHK  = 2'b11
    } state_t;

    function automatic logic [7:0] apply_op(input opcode_t op, input logic [7:0] cur,
                                            input logic [7:0] data);
        case (op)
            OP_WRITE: apply_op = data;
            OP_SET:   apply_op = cur | data;
            OP_CLR:   apply_op = cur & ~data;
            default:  apply_op = cur ^ data;
        endcase
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// rtl/cmd_timeout_timer.sv - inter-byte gap counter that saturates at TIMEOUT_CYCLES-1
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 15625
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_cmd_controller.sv
// rtl/uart_cmd_controller.sv - decodes SOF/ADDR/DATA/CHK frames into four device control registers
module uart_cmd_controller
    import uart_cmd_defs::*;
#(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int TIMEOUT_CYCLES = 3 * 10 * CLOCK_FREQ / BAUD_RATE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] dev_ctrl,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    state_t          state;
    logic [7:0]      addr_q;
    logic [7:0]      data_q;
    logic [3:0][7:0] dev_q;
    err_code_t       err_q;
    logic            pend_done;
    logic            pend_err;
    err_code_t       pend_code;
    logic            expired;
    logic            timeout_hit;

    assign busy        = (state != IDLE);
    assign timeout_hit = busy && expired && !rx_valid;
    assign dev_ctrl    = dev_q;
    assign err_code    = err_q;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid || !busy),
        .enable (busy),
        .expired(expired)
    );

    // Outcome is decided on the CHK edge and applied one edge later; addr_q/data_q
    // stay stable across that cycle because the next frame cannot reach ADDR sooner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            dev_q     <= '0;
            err_q     <= ERR_NONE;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            pend_done <= 1'b0;
            pend_err  <= 1'b0;
            pend_code <= ERR_NONE;
        end else begin
            cmd_done  <= pend_done;
            cmd_err   <= pend_err;
            pend_done <= 1'b0;
            pend_err  <= 1'b0;
            if (pend_done) begin
                dev_q[addr_q[1:0]] <= apply_op(opcode_t'(addr_q[7:6]), dev_q[addr_q[1:0]], data_q);
                err_q              <= ERR_NONE;
            end else if (pend_err) begin
                err_q <= pend_code;
            end

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_data == SOF) state <= WAIT_ADDR;
                    end
                    WAIT_ADDR: begin
                        addr_q <= rx_data;
                        state  <= WAIT_DATA;
                    end
                    WAIT_DATA: begin
                        data_q <= rx_data;
                        state  <= WAIT_CHK;
                    end
                    default: begin
                        state <= IDLE;
                        if (rx_data != (SOF ^ addr_q ^ data_q)) begin
                            pend_err  <= 1'b1;
                            pend_code <= ERR_CHK;
                        end else if (addr_q[5:2] != 4'b0000) begin
                            pend_err  <= 1'b1;
                            pend_code <= ERR_ADDR;
                        end else begin
                            pend_done <= 1'b1;
                        end
                    end
                endcase
            end else if (timeout_hit) begin
                state     <= IDLE;
                pend_err  <= 1'b1;
                pend_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule
